// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//   Shared definitions for the I2S transmitter/receiver pair.
//   - WIDTH_DEF : default sample width, common to both directions
//   - CH_LEFT / CH_RIGHT : lrclk levels for each channel
//   - rx_state_e : receiver FSM encoding
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    typedef enum logic {
        UNSYNCED = 1'b0,
        RUN      = 1'b1
    } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// -----------------------------------------------------------------------------
// i2s_rx_sync
//   Brings the asynchronous I2S pins into the clk domain. Each pin goes through
//   a 2-FF synchronizer; sclk gets a third flop for rising-edge detection. The
//   edge strobe and the lrclk/din samples are registered once more together,
//   so all three outputs carry the values present at the same sclk rise.
//
// Ports
//   clk_i        system clock
//   rst_n_i      synchronous active-low reset
//   sclk_i       I2S bit clock (async)
//   lrclk_i      word select (async)
//   din_i        serial data (async)
//   sclk_rise_o  one-cycle strobe per sclk rising edge
//   lr_s_o       lrclk sampled at that rise
//   din_s_o      din sampled at that rise
// -----------------------------------------------------------------------------
module i2s_rx_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sclk_i,
    input  logic lrclk_i,
    input  logic din_i,
    output logic sclk_rise_o,
    output logic lr_s_o,
    output logic din_s_o
);

    logic sclk_meta_q;
    logic sclk_sync_q;
    logic sclk_last_q;
    logic lr_meta_q;
    logic lr_sync_q;
    logic din_meta_q;
    logic din_sync_q;
    logic rise_q;
    logic lr_q;
    logic din_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_last_q <= 1'b0;
            lr_meta_q   <= 1'b0;
            lr_sync_q   <= 1'b0;
            din_meta_q  <= 1'b0;
            din_sync_q  <= 1'b0;
            rise_q      <= 1'b0;
            lr_q        <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_last_q <= sclk_sync_q;
            lr_meta_q   <= lrclk_i;
            lr_sync_q   <= lr_meta_q;
            din_meta_q  <= din_i;
            din_sync_q  <= din_meta_q;
            // Edge strobe and data samples share this final stage so that
            // lr_q/din_q are exactly the values seen at the detected rise.
            rise_q      <= sclk_sync_q & ~sclk_last_q;
            lr_q        <= lr_sync_q;
            din_q       <= din_sync_q;
        end
    end

    assign sclk_rise_o = rise_q;
    assign lr_s_o      = lr_q;
    assign din_s_o     = din_q;

endmodule

// File: rtl/i2s_receiver.sv
// -----------------------------------------------------------------------------
// i2s_receiver
//   Slave-mode I2S receiver. Samples externally driven sclk/lrclk/din, recovers
//   one left and one right MSB-first two's-complement word per frame and
//   presents them as a registered stereo pair with a one-cycle valid strobe.
//
//   Optional feature macro: I2S_RX_MONO_EN adds mono_o, the registered average
//   of left and right, updated together with left_o/right_o.
//
// Ports
//   clk48m_i  system clock
//   rst_n_i   synchronous active-low reset
//   sclk_i    I2S bit clock (async)
//   lrclk_i   word select, 0 = left, 1 = right (async)
//   din_i     serial data (async)
//   left_o    last completed left word
//   right_o   last completed right word
//   mono_o    (I2S_RX_MONO_EN only) (left + right) >>> 1
//   valid_o   one-cycle pulse when left_o/right_o update
//   synced_o  high once the first lrclk edge after reset has been seen
//
// FSM states
//   state    | meaning
//   ---------+------------------------------------------------------------
//   UNSYNCED | after reset; data ignored, waiting for an lrclk transition
//   RUN      | framed; shifting bits, closing a word on each lrclk change
// -----------------------------------------------------------------------------
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk48m_i,
    input  logic             rst_n_i,
    input  logic             sclk_i,
    input  logic             lrclk_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] left_o,
    output logic [WIDTH-1:0] right_o,
`ifdef I2S_RX_MONO_EN
    output logic [WIDTH-1:0] mono_o,
`endif
    output logic             valid_o,
    output logic             synced_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    logic sclk_rise;
    logic lr_s;
    logic din_s;

    i2s_rx_sync u_sync (
        .clk_i       (clk48m_i),
        .rst_n_i     (rst_n_i),
        .sclk_i      (sclk_i),
        .lrclk_i     (lrclk_i),
        .din_i       (din_i),
        .sclk_rise_o (sclk_rise),
        .lr_s_o      (lr_s),
        .din_s_o     (din_s)
    );

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             lr_prev_q;
    logic [WIDTH-1:0] left_hold_q;
    logic             left_seen_q;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic             valid_q;
    logic             synced_q;

    logic             room;
    logic [WIDTH-1:0] shreg_shift;
    logic [CNT_W-1:0] cnt_sat;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] word_d;

    // Bits past WIDTH are counted but not stored.
    assign room        = (cnt_q < WIDTH_CNT);
    assign shreg_shift = {shreg_q[WIDTH-2:0], din_s};
    assign cnt_sat     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Completed word as it would be closed on this edge. When there is still
    // room, the closing bit is shifted in and the result is left-aligned so a
    // short word is zero-padded in its LSBs. A full register is already aligned.
    always_comb begin
        shamt  = '0;
        word_d = shreg_q;
        if (room) begin
            shamt  = WIDTH_CNT - cnt_q - CNT_ONE;
            word_d = shreg_shift << shamt;
        end
    end

`ifdef I2S_RX_MONO_EN
    logic [WIDTH:0]   mono_sum;
    logic [WIDTH-1:0] mono_d;
    logic [WIDTH-1:0] mono_q;

    // Sign-extend both channels to WIDTH+1 bits; dropping the LSB of the sum
    // is the arithmetic shift right by one.
    assign mono_sum = {left_hold_q[WIDTH-1], left_hold_q} + {word_d[WIDTH-1], word_d};
    assign mono_d   = mono_sum[WIDTH:1];
`endif

    always_ff @(posedge clk48m_i) begin
        if (!rst_n_i) begin
            state_q     <= UNSYNCED;
            cnt_q       <= '0;
            shreg_q     <= '0;
            lr_prev_q   <= 1'b0;
            left_hold_q <= '0;
            left_seen_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            synced_q    <= 1'b0;
`ifdef I2S_RX_MONO_EN
            mono_q      <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (sclk_rise) begin
                lr_prev_q <= lr_s;
                case (state_q)
                    UNSYNCED: begin
                        if (lr_s != lr_prev_q) begin
                            state_q  <= RUN;
                            synced_q <= 1'b1;
                            cnt_q    <= '0;
                            shreg_q  <= '0;
                        end
                    end
                    RUN: begin
                        if (lr_s == lr_prev_q) begin
                            if (room) begin
                                shreg_q <= shreg_shift;
                            end
                            cnt_q <= cnt_sat;
                        end else begin
                            // One-bit I2S delay: this edge still carries the
                            // last bit of the channel that just ended.
                            if (lr_prev_q == CH_LEFT) begin
                                left_hold_q <= word_d;
                                left_seen_q <= 1'b1;
                            end else if (left_seen_q) begin
                                left_q  <= left_hold_q;
                                right_q <= word_d;
                                valid_q <= 1'b1;
`ifdef I2S_RX_MONO_EN
                                mono_q  <= mono_d;
`endif
                            end
                            cnt_q   <= '0;
                            shreg_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= UNSYNCED;
                    end
                endcase
            end
        end
    end

    assign left_o   = left_q;
    assign right_o  = right_q;
    assign valid_o  = valid_q;
    assign synced_o = synced_q;
`ifdef I2S_RX_MONO_EN
    assign mono_o   = mono_q;
`endif

endmodule
